serial_packet_receiver: RTL and testbench
=========================================

// Module: serial_packet_receiver
// PURPOSE
//   Deserializes the single-wire packet stream from the serial packet sender
//   (idle-low line, 1 start bit, 40 data bits MSB first, one bit per clk).
//   Decodes the audio-sample-request and audio-underrun control packets into
//   one-cycle strobes. Presents all other packets on a 1-deep valid/ready
//   output register. Sits at the far end of the link and feeds the audio and
//   keyboard/mouse consumers.
// PARAMETERS
//   DATA_W       40      payload bits per frame, excluding the start bit
//   SYNC_STAGES  2       flip-flops in the sin synchronizer (>=2)
//   AUDIO_REQ    8'h07   top byte of the audio sample request packet
//   UNDERRUN     8'h0f   top byte of the audio underrun packet
// PORTS
//   clk             in   1       single clock; sender and receiver share bit rate
//   rst             in   1       synchronous, active-high reset
//   sin             in   1       serial in; idle low
//   out_data        out  40      received data packet
//   out_valid       out  1       out_data holds an unconsumed packet
//   out_ready       in   1       consumer accepts out_data when out_valid&&out_ready
//   audio_req_tick  out  1       1-cycle pulse: audio sample request packet received
//   underrun_tick   out  1       1-cycle pulse: audio underrun packet received
//   data_loss       out  1       1-cycle pulse: data packet dropped, output register full
//   loss_count      out  8       saturating count of dropped packets
// BEHAVIOUR
// - Reset: all outputs 0, synchronizer flops 0, FSM=ARM, bit counter 0.
//   A frame in flight when rst asserts is abandoned and never emitted.
// - sin passes through SYNC_STAGES flops to give sin_s. The FSM samples only sin_s.
// - FSM:
//   - ARM:  wait for sin_s==0, then go to IDLE. Guards against a mid-frame
//     start after reset.
//   - IDLE: sin_s==1 is the start bit. Go to DATA with cnt=0.
//   - DATA: shift sin_s into shreg (MSB first). cnt++.
//     On cnt==DATA_W-1 the frame completes: classify, then go to ARM.
// - Classification uses the full 40-bit word w = {shreg[38:0], sin_s}:
//   - w=={AUDIO_REQ,32'h0} -> audio_req_tick=1 next cycle
//   - w=={UNDERRUN,32'h0}  -> underrun_tick=1 next cycle
//   - else data packet
//   Control packets never touch out_data or out_valid and are never dropped.
// - Latency: out_valid (or a tick) goes high on clock edge SYNC_STAGES+DATA_W
//   after the edge that first samples the start bit on sin. Default: edge 42.
// - Output register, per-cycle priority:
//   - pop = out_valid&&out_ready.
//   - Data completion with (!out_valid || pop): load out_data; out_valid stays
//     or goes 1.
//   - Data completion with out_valid&&!out_ready: drop the new packet; out_data
//     unchanged; data_loss=1 for one cycle; loss_count++ saturating at 8'hff.
//   - pop with no completion: out_valid=0. out_data keeps its last value.
// - out_data must stay stable while out_valid&&!out_ready.
// - Minimum frame spacing: one idle-low bit after the last data bit (ARM).
//   A 1 on the bit right after a frame is not a start. The sender's gap is
//   always >=3 bits.
// - A line stuck high after a frame holds the FSM in ARM. Nothing is emitted.
// STRUCTURE
// - Package next_serial_pkg: FRAME_DATA_W=40, AUDIO_REQ_CODE=8'h07,
//   UNDERRUN_CODE=8'h0f, state enum {ARM,IDLE,DATA}. Shared with the sender
//   testbench model.
// - Sub-module: bit_sync (SYNC_STAGES-deep synchronizer, sync reset to 0).
// - This module holds the FSM, a 6-bit cnt, the 39-bit shreg, the output
//   register and the loss counter.
// TESTING
// - Single frame 1,40'h12_3456_789A then idle, out_ready=1:
//   out_valid=1 for one cycle at edge 42, out_data=40'h123456789A.
// - Frame 1,40'h07_0000_0000: audio_req_tick pulses once at edge 42;
//   out_valid stays 0.
// - Frame 1,40'h0F_0000_0000: underrun_tick pulses once.
// - Frame 1,40'h07_0000_0001: this is a data packet; out_data=40'h0700000001;
//   no tick.
// - out_ready=0, two data frames 3 idle bits apart: first is held; data_loss
//   pulses once; loss_count=1; out_data unchanged. Then raise out_ready:
//   out_valid drops after one cycle.
// - rst for one cycle mid-frame (bit 20), sin continues the frame: no outputs
//   for that frame. The next clean frame is received correctly.
// - Back-to-back: frames with 0-bit gap -> the second frame is not decoded.
//   Frames with a 1-bit gap -> both frames are decoded.

Source files
------------

// File: rtl/next_serial_pkg.sv
// Shared definitions for the serial packet link: frame geometry, the top-byte
// codes of the two audio control packets, and the receiver state encoding.
package next_serial_pkg;

   localparam int         FRAME_DATA_W   = 40;
   localparam logic [7:0] AUDIO_REQ_CODE = 8'h07;
   localparam logic [7:0] UNDERRUN_CODE  = 8'h0f;

   // ARM waits for a low line, IDLE hunts for a start bit, DATA collects bits.
   typedef enum logic [1:0] {
      ARM,
      IDLE,
      DATA
   } rx_state_t;

endpackage

// File: rtl/serial_packet_receiver_bit_sync.sv
// Multi-flop synchronizer for the incoming serial line. Clears to 0 on reset,
// so the receiver always sees an idle-low line right after reset.
module bit_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Shift the raw input through the flop chain; the oldest bit is the output.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/serial_packet_receiver.sv
// Far-end receiver of the serial packet link. Deserializes start-bit framed
// words, turns the audio request/underrun control packets into one-cycle
// ticks, and holds every other packet in a 1-deep valid/ready register.
// Packets arriving while that register is still full are dropped and counted.
module serial_packet_receiver
   import next_serial_pkg::*;
#(
   parameter int         DATA_W      = FRAME_DATA_W,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] AUDIO_REQ   = AUDIO_REQ_CODE,
   parameter logic [7:0] UNDERRUN    = UNDERRUN_CODE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sin,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              audio_req_tick,
   output logic              underrun_tick,
   output logic              data_loss,
   output logic [7:0]        loss_count
);

   localparam logic [5:0]        LAST_BIT      = 6'(DATA_W - 1);
   localparam logic [DATA_W-1:0] AUDIO_WORD    = {AUDIO_REQ, {(DATA_W-8){1'b0}}};
   localparam logic [DATA_W-1:0] UNDERRUN_WORD = {UNDERRUN, {(DATA_W-8){1'b0}}};

   logic              sin_s;
   rx_state_t         state;
   logic [5:0]        cnt;
   logic [DATA_W-2:0] shreg;
   logic [DATA_W-1:0] frame_word;
   logic              pop;

   bit_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (sin),
      .q  (sin_s)
   );

   // The bit being sampled this cycle completes the word when cnt hits the end.
   assign frame_word = {shreg, sin_s};
   assign pop        = out_valid && out_ready;

   // Framing FSM, classifier and output register share one clocked process so
   // a completing frame and a consumer pop in the same cycle resolve together:
   // the pop clears out_valid first, and a loaded data packet then sets it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ARM;
         cnt            <= '0;
         shreg          <= '0;
         out_data       <= '0;
         out_valid      <= 1'b0;
         audio_req_tick <= 1'b0;
         underrun_tick  <= 1'b0;
         data_loss      <= 1'b0;
         loss_count     <= '0;
      end else begin
         audio_req_tick <= 1'b0;
         underrun_tick  <= 1'b0;
         data_loss      <= 1'b0;

         if (pop) begin
            out_valid <= 1'b0;
         end

         case (state)
            ARM: begin
               if (!sin_s) begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (sin_s) begin
                  state <= DATA;
                  cnt   <= '0;
               end
            end
            DATA: begin
               shreg <= {shreg[DATA_W-3:0], sin_s};
               cnt   <= cnt + 6'd1;
               if (cnt == LAST_BIT) begin
                  state <= ARM;
                  if (frame_word == AUDIO_WORD) begin
                     audio_req_tick <= 1'b1;
                  end else if (frame_word == UNDERRUN_WORD) begin
                     underrun_tick <= 1'b1;
                  end else if (!out_valid || out_ready) begin
                     out_data  <= frame_word;
                     out_valid <= 1'b1;
                  end else begin
                     data_loss <= 1'b1;
                     if (loss_count != 8'hff) begin
                        loss_count <= loss_count + 8'd1;
                     end
                  end
               end
            end
            default: begin
               state <= ARM;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_packet_receiver.sv
// Bench for serial_packet_receiver: directed frames driven bit by bit, a
// behavioural line/packet model checked against the DUT every cycle, and
// literal expectations for latency, payloads and event counts.
module tb_serial_packet_receiver;

   logic        clk = 1'b0;
   logic        rst;
   logic        sin;
   logic        out_ready;
   logic [39:0] out_data;
   logic        out_valid;
   logic        audio_req_tick;
   logic        underrun_tick;
   logic        data_loss;
   logic [7:0]  loss_count;

   int tests = 0;
   int fails = 0;
   int cycle = 0;
   bit check_en = 1'b0;

   // Behavioural model state
   bit          m_line[$];
   bit          m_bits[$];
   bit          m_armed;
   bit          m_collecting;
   logic [39:0] m_data;
   bit          m_valid;
   bit          m_areq;
   bit          m_urun;
   bit          m_loss;
   int          m_loss_cnt;

   // Observations of DUT events for the literal checks
   int          rises_n;
   int          valid_rise_edge;
   logic [39:0] valid_rise_data;
   int          valid_cycles;
   int          areq_n;
   int          areq_edge;
   int          urun_n;
   int          urun_edge;
   int          loss_n;
   bit          prev_valid = 1'b0;

   always #5 clk = ~clk;

   serial_packet_receiver dut (
      .clk           (clk),
      .rst           (rst),
      .sin           (sin),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .audio_req_tick(audio_req_tick),
      .underrun_tick (underrun_tick),
      .data_loss     (data_loss),
      .loss_count    (loss_count)
   );

   task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Model of the link: the line reaches the receiver two clocks late, a frame
   // may only begin once the line has been seen low, and 40 bits after a start
   // bit the word is classified and handed to the 1-deep output register.
   always @(posedge clk) begin
      bit          seen;
      bit          pop;
      bit          data_done;
      logic [39:0] w;
      cycle++;
      m_areq = 1'b0;
      m_urun = 1'b0;
      m_loss = 1'b0;
      if (rst) begin
         m_line = {};
         m_line.push_back(1'b0);
         m_line.push_back(1'b0);
         m_bits.delete();
         m_armed      = 1'b0;
         m_collecting = 1'b0;
         m_data       = '0;
         m_valid      = 1'b0;
         m_loss_cnt   = 0;
      end else begin
         pop       = m_valid && out_ready;
         data_done = 1'b0;
         seen      = m_line.pop_front();
         m_line.push_back(sin);
         if (m_collecting) begin
            m_bits.push_back(seen);
            if (m_bits.size() == 40) begin
               w = '0;
               foreach (m_bits[i]) w = {w[38:0], m_bits[i]};
               m_collecting = 1'b0;
               m_armed      = 1'b0;
               if (w == 40'h07_0000_0000) m_areq = 1'b1;
               else if (w == 40'h0f_0000_0000) m_urun = 1'b1;
               else begin
                  data_done = 1'b1;
                  if (!m_valid || pop) begin
                     m_data  = w;
                     m_valid = 1'b1;
                  end else begin
                     m_loss = 1'b1;
                     if (m_loss_cnt < 255) m_loss_cnt++;
                  end
               end
            end
         end else if (!m_armed) begin
            m_armed = (seen == 1'b0);
         end else if (seen) begin
            m_collecting = 1'b1;
            m_bits.delete();
         end
         if (pop && !data_done) m_valid = 1'b0;
      end
   end

   // Every cycle, compare all outputs with the model and log DUT events.
   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("out_valid", 40'(out_valid), 40'(m_valid));
         checkOutput("out_data", out_data, m_data);
         checkOutput("audio_req_tick", 40'(audio_req_tick), 40'(m_areq));
         checkOutput("underrun_tick", 40'(underrun_tick), 40'(m_urun));
         checkOutput("data_loss", 40'(data_loss), 40'(m_loss));
         checkOutput("loss_count", 40'(loss_count), 40'(m_loss_cnt));
      end
      if (out_valid === 1'b1 && !prev_valid) begin
         rises_n++;
         valid_rise_edge = cycle;
         valid_rise_data = out_data;
      end
      if (out_valid === 1'b1) valid_cycles++;
      if (audio_req_tick === 1'b1) begin
         areq_n++;
         areq_edge = cycle;
      end
      if (underrun_tick === 1'b1) begin
         urun_n++;
         urun_edge = cycle;
      end
      if (data_loss === 1'b1) loss_n++;
      prev_valid = (out_valid === 1'b1);
   end

   task automatic clearObs();
      rises_n         = 0;
      valid_rise_edge = -1;
      valid_rise_data = '0;
      valid_cycles    = 0;
      areq_n          = 0;
      areq_edge       = -1;
      urun_n          = 0;
      urun_edge       = -1;
      loss_n          = 0;
   endtask

   // Drive one bit on the line for one clock.
   task automatic applyStimulus(input bit b);
      sin = b;
      @(negedge clk);
   endtask

   task automatic idleBits(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0);
   endtask

   // Send start bit plus 40 data bits MSB first; rst pulses during data bit
   // rst_bit (no pulse when negative). Returns the edge sampling the start bit.
   task automatic sendFrame(input logic [39:0] data, input int rst_bit, output int start_edge);
      start_edge = cycle + 1;
      applyStimulus(1'b1);
      for (int i = 0; i < 40; i++) begin
         rst = (i == rst_bit);
         applyStimulus(data[39-i]);
      end
      rst = 1'b0;
   endtask

   initial begin
      int e0;
      int e1;
      rst       = 1'b1;
      sin       = 1'b0;
      out_ready = 1'b1;
      clearObs();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_en = 1'b1;
      checkOutput("reset out_valid", 40'(out_valid), 40'h0);
      checkOutput("reset loss_count", 40'(loss_count), 40'h0);
      idleBits(4);

      // Single data frame, consumer always ready
      clearObs();
      sendFrame(40'h12_3456_789A, -1, e0);
      idleBits(8);
      checkOutput("data latency", 40'(valid_rise_edge - e0), 40'd42);
      checkOutput("data payload", valid_rise_data, 40'h12_3456_789A);
      checkOutput("data valid cycles", 40'(valid_cycles), 40'd1);

      // Audio sample request
      clearObs();
      sendFrame(40'h07_0000_0000, -1, e0);
      idleBits(8);
      checkOutput("areq count", 40'(areq_n), 40'd1);
      checkOutput("areq latency", 40'(areq_edge - e0), 40'd42);
      checkOutput("areq no valid", 40'(rises_n), 40'd0);

      // Audio underrun
      clearObs();
      sendFrame(40'h0F_0000_0000, -1, e0);
      idleBits(8);
      checkOutput("urun count", 40'(urun_n), 40'd1);
      checkOutput("urun latency", 40'(urun_edge - e0), 40'd42);
      checkOutput("urun no valid", 40'(rises_n), 40'd0);

      // Near-miss of a control code is plain data
      clearObs();
      sendFrame(40'h07_0000_0001, -1, e0);
      idleBits(8);
      checkOutput("nearmiss payload", valid_rise_data, 40'h07_0000_0001);
      checkOutput("nearmiss no tick", 40'(areq_n + urun_n), 40'd0);

      // Consumer stalled: second packet dropped, first held stable
      clearObs();
      out_ready = 1'b0;
      sendFrame(40'h11_1111_1111, -1, e0);
      idleBits(3);
      sendFrame(40'h22_2222_2222, -1, e1);
      idleBits(6);
      checkOutput("stall held valid", 40'(out_valid), 40'h1);
      checkOutput("stall held data", out_data, 40'h11_1111_1111);
      checkOutput("stall loss pulses", 40'(loss_n), 40'd1);
      checkOutput("stall loss_count", 40'(loss_count), 40'd1);
      sendFrame(40'h07_0000_0000, -1, e0);
      idleBits(6);
      checkOutput("stall areq passes", 40'(areq_n), 40'd1);
      checkOutput("stall areq no loss", 40'(loss_count), 40'd1);
      out_ready = 1'b1;
      idleBits(1);
      checkOutput("stall pop", 40'(out_valid), 40'h0);
      checkOutput("stall data kept", out_data, 40'h11_1111_1111);
      idleBits(4);

      // Reset mid-frame abandons it; the next frame is clean
      clearObs();
      sendFrame(40'hAB_CDE0_0000, 20, e0);
      idleBits(8);
      checkOutput("rst no output", 40'(rises_n + areq_n + urun_n), 40'd0);
      checkOutput("rst loss_count", 40'(loss_count), 40'd0);
      sendFrame(40'h5A_5A5A_5A5A, -1, e0);
      idleBits(8);
      checkOutput("post-rst latency", 40'(valid_rise_edge - e0), 40'd42);
      checkOutput("post-rst payload", valid_rise_data, 40'h5A_5A5A_5A5A);

      // Zero-gap back-to-back: second frame is not a frame
      clearObs();
      sendFrame(40'h3C_3C3C_3C3C, -1, e0);
      sendFrame(40'hFF_FFFF_FFFF, -1, e1);
      idleBits(8);
      checkOutput("gap0 count", 40'(rises_n), 40'd1);
      checkOutput("gap0 payload", valid_rise_data, 40'h3C_3C3C_3C3C);

      // One-bit gap: both frames decoded
      clearObs();
      sendFrame(40'h01_0203_0405, -1, e0);
      idleBits(1);
      sendFrame(40'hA0_B0C0_D0E0, -1, e1);
      idleBits(8);
      checkOutput("gap1 count", 40'(rises_n), 40'd2);
      checkOutput("gap1 latency", 40'(valid_rise_edge - e1), 40'd42);
      checkOutput("gap1 payload", valid_rise_data, 40'hA0_B0C0_D0E0);

      // Loss counter saturates at 255
      clearObs();
      out_ready = 1'b0;
      sendFrame(40'h44_4444_4444, -1, e0);
      idleBits(3);
      for (int k = 0; k < 256; k++) begin
         sendFrame(40'(k + 40'h10_0000_0000), -1, e1);
         idleBits(3);
      end
      idleBits(4);
      checkOutput("sat loss pulses", 40'(loss_n), 40'd256);
      checkOutput("sat loss_count", 40'(loss_count), 40'hff);
      checkOutput("sat data held", out_data, 40'h44_4444_4444);
      out_ready = 1'b1;
      idleBits(4);

      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
